// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam int unsigned DIV_OP_UNSIGNED = 0;
  localparam int unsigned DIV_OP_REM      = 1;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic [DATA_WIDTH-1:0] quo_o
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;
  logic                fits;

  // rem < divisor always holds, so the (W+1)-bit difference's MSB is set exactly when it underflows.
  always_comb begin
    shifted = {rem_i, quo_i[DATA_WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    fits    = ~trial[DATA_WIDTH];
    rem_o   = fits ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_o   = {quo_i[DATA_WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit with valid/ready handshakes and flush.
module div_iter
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [1:0]            div_op,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [1:0]            op_q, op_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;

  logic [DATA_WIDTH-1:0] step_rem, step_quo;
  logic                  is_signed, a_neg, b_neg;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    op_d      = op_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    is_signed = ~op_q[DIV_OP_UNSIGNED];
    a_neg     = is_signed & quo_q[DATA_WIDTH-1];
    b_neg     = is_signed & dvs_q[DATA_WIDTH-1];

    unique case (state_q)
      IDLE: begin
        // Raw operands park in quo/dvs until PREP takes their magnitudes.
        if (in_valid) begin
          state_d = PREP;
          quo_d   = data_a;
          dvs_d   = data_b;
          op_d    = div_op;
        end
      end
      PREP: begin
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        rem_d  = '0;
        cnt_d  = '0;
        if (dvs_q == '0) begin
          result_d = op_q[DIV_OP_REM] ? quo_q : '1;
          state_d  = DONE;
        end else if (is_signed && quo_q == MOST_NEG && dvs_q == '1) begin
          result_d = op_q[DIV_OP_REM] ? '0 : quo_q;
          state_d  = DONE;
        end else begin
          quo_d   = a_neg ? -quo_q : quo_q;
          dvs_d   = b_neg ? -dvs_q : dvs_q;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = op_q[DIV_OP_REM] ? (rneg_q ? -rem_q : rem_q)
                                    : (qneg_q ? -quo_q : quo_q);
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: vector table, random model vectors, and handshake corner cases.
module tb_div_iter;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_a = '0;
  logic [31:0] data_b = '0;
  logic [1:0]  div_op = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[16];

  div_iter #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_a    (data_a),
    .data_b    (data_b),
    .div_op    (div_op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
    if (op[0]) return op[1] ? a % b : a / b;
    return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, check latency and result, hold DONE for `hold` cycles, then accept.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input int hold);
    int          cyc;
    logic [31:0] want;
    step();
    check("in_ready_before_op", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    data_a   = a;
    data_b   = b;
    div_op   = op;
    step();
    in_valid = 1'b0;
    sb.push_back(exp);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    check("latency", 32'(cyc), 32'(lat));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    want = sb.pop_front();
    check("result", result, want);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_result", result, want);
      check("hold_valid_ready", {30'b0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_after_accept", {30'b0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    vt[0]  = '{DIV,  32'd100,        32'd7,          32'd14,         35};
    vt[1]  = '{REM,  32'd100,        32'd7,          32'd2,          35};
    vt[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35};
    vt[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35};
    vt[4]  = '{DIVU, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  35};
    vt[5]  = '{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
    vt[6]  = '{REM,  32'd5,          32'd0,          32'd5,          2};
    vt[7]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
    vt[8]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          2};
    vt[9]  = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          35};
    vt[10] = '{REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  35};
    vt[11] = '{DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  35};
    vt[12] = '{REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  35};
    vt[13] = '{DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  35};
    vt[14] = '{REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          35};
    vt[15] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35};

    #2;
    check("reset_state", {result[27:0], out_valid, busy, in_ready, 1'b0}, 32'b0010);
    #20;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, vt[i].lat, 0);
    end

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 11) b = 32'd0;
      run_op(op, a, b, model(op, a, b), (b == 0) ? 2 : 35, 0);
    end

    // Back-pressure: result held 10 cycles in DONE.
    run_op(DIVU, 32'd1000, 32'd9, 32'd111, 35, 10);

    // Flush in IDLE wins over a pending request.
    step();
    in_valid = 1'b1;
    flush    = 1'b1;
    data_a   = 32'd50;
    data_b   = 32'd5;
    div_op   = DIVU;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle_blocks_accept", {30'b0, busy, in_ready}, 32'b01);

    // Flush 10 cycles into CALC.
    step();
    in_valid = 1'b1;
    data_a   = 32'd12345;
    data_b   = 32'd3;
    div_op   = DIVU;
    step();
    in_valid = 1'b0;
    repeat (11) step();
    check("busy_mid_calc", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_to_idle", {29'b0, out_valid, busy, in_ready}, 32'b001);
    begin
      int seen = 0;
      repeat (40) begin
        step();
        if (out_valid) seen++;
      end
      check("no_valid_after_flush", 32'(seen), 32'd0);
    end
    run_op(DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 35, 0);

    // Asynchronous reset mid-CALC.
    step();
    in_valid = 1'b1;
    data_a   = 32'd999;
    data_b   = 32'd4;
    div_op   = DIV;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {29'b0, out_valid, busy, in_ready}, 32'b001);
    step();
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (40) begin
        step();
        if (out_valid || busy) seen++;
      end
      check("no_result_after_reset", 32'(seen), 32'd0);
    end
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);
    run_op(REMU, 32'd100, 32'd7, 32'd2, 35, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle, parametrised integer divider for the pipeline CPU's M-extension path. It replaces the single-cycle combinational divider in the EX stage. It implements RISC-V DIV/DIVU/REM/REMU semantics with one restoring-division step per cycle and exchanges operands and results over valid/ready handshakes. A flush input supports squashed instructions.

## Interface
- `DATA_WIDTH`, default 32: operand and result width; must be ≥ 2.
- `CNT_W`, default `$clog2(DATA_WIDTH+1)`: iteration counter width; derived, do not override.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operands and op are valid.
- `in_ready`, output, 1: divider can accept; equals (state == IDLE).
- `data_a`, input, `DATA_WIDTH`: dividend.
- `data_b`, input, `DATA_WIDTH`: divisor.
- `div_op`, input, 2: bit0 = 1 unsigned / 0 signed; bit1 = 1 remainder / 0 quotient.
- `flush`, input, 1: abort any in-flight operation.
- `out_valid`, output, 1: result valid; held until accepted.
- `out_ready`, input, 1: consumer accepts the result.
- `result`, output, `DATA_WIDTH`: quotient or remainder, per the latched op.
- `busy`, output, 1: state != IDLE.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE → PREP on in_valid & in_ready.
  - On that edge, latch a, b and op.
- PREP takes one cycle. It computes |a| and |b| (raw values if unsigned), records the quotient and remainder signs, and detects special cases.
  - Divide by zero (b == 0): quotient = all ones; remainder = a. Go to DONE.
  - Signed overflow (signed op, a == 1 followed by zeros (most negative value), b == all ones): quotient = a; remainder = 0. Go to DONE.
  - Otherwise clear the partial remainder and the counter, then go to CALC.
- CALC runs for exactly DATA_WIDTH cycles, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper DATA_WIDTH+1 bits.
  - If the trial is non-negative, keep the difference and set the quotient LSB to 1.
- FIX takes one cycle:
  - Negate the quotient if the signs of a and b differ (signed ops only).
  - Negate the remainder if a is negative (signed ops only).
  - Select quotient or remainder via op bit1 into the result register.
- DONE: out_valid = 1 and result stays stable. On out_ready, go to IDLE.
- flush, any state: next state is IDLE, out_valid drops on the next edge, and the result is discarded.
  - In IDLE, flush has priority over acceptance: no operation is accepted in a flush cycle.
- Only one operation is in flight. in_ready stays 0 from PREP through DONE, including the cycle in which out_ready is accepted.
- Arithmetic: the trial subtraction is DATA_WIDTH+1 bits wide so no carry is lost. Negation is two's complement modulo 2^DATA_WIDTH.

## Timing
- Reset values (asserted asynchronously, held while rst_n = 0):
  - state = IDLE; out_valid = 0; result = 0; busy = 0; counter = 0.
  - in_ready follows state, so it is 1 during and after reset.
- Latency is measured from the handshake edge (cycle 0) to the first cycle with out_valid high.
  - Normal operations: DATA_WIDTH + 3 cycles (35 for W = 32).
  - Special cases: 2 cycles.
- Throughput: at most one operation per (latency + 1) cycles with out_ready held high.
- Back-pressure: result and out_valid hold indefinitely while out_ready = 0.
- Reset mid-operation: the operation is lost and no result appears after reset is released.
- in_valid during busy is ignored; the upstream stage must hold its request.

## Structure
- Package `div_pkg` holds:
  - the `div_state_e` enum (IDLE, PREP, CALC, FIX, DONE);
  - the `div_op` bit-position constants `DIV_OP_UNSIGNED = 0` and `DIV_OP_REM = 1`;
  - the `DIV_OP` enum values DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11.
- Sub-module `div_step`: combinational single restoring iteration, parametrised by DATA_WIDTH.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- div_iter holds the FSM, counter, operand and sign registers, and the FIX logic.

## Test plan
- DIV 100 / 7, then REM 100 / 7 → result 14, then 2; each has out_valid first high 35 cycles after the handshake.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU of the same operands → 0x7FFFFFFC.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with out_valid high 2 cycles after the handshake; signed DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0.
- out_ready held 0 for 10 cycles in DONE → result and out_valid stable and in_ready = 0 throughout; IDLE on the cycle after acceptance.
- flush asserted 10 cycles into CALC → IDLE on the next edge with no out_valid; the next operation, DIVU 0xFFFFFFFF / 0x10, returns 0x0FFFFFFF.
- rst_n pulled low mid-CALC → out_valid = 0 and busy = 0 immediately (asynchronously); in_ready = 1 after release.
